// File: rtl/kgp_boot_pkg.sv
// Shared types and constants for the KGP-RISC program loader.
// The state enum is used by the loader FSM and the frame constants by the datapath.
package kgp_boot_pkg;

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CHK,
      S_DONE,
      S_ERR
   } boot_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/kgp_boot_if.sv
// Host byte-stream link into the loader.
// The host is the master, and the loader is the slave.
interface kgp_boot_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );

endinterface

// File: rtl/kgp_word_assembler.sv
// Big-endian byte-to-word assembler with a 2-bit byte counter.
// word_valid pulses combinationally together with the last byte of a word.
module kgp_word_assembler
   import kgp_boot_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [7:0]        din,
   output logic [WORD_W-1:0] word,
   output logic              word_valid
);

   logic [WORD_W-9:0] sh_q;
   logic [1:0]        cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q  <= '0;
         cnt_q <= '0;
      end else if (en) begin
         sh_q  <= {sh_q[WORD_W-17:0], din};
         cnt_q <= cnt_q + 2'd1;
      end
   end

   assign word_valid = en && (cnt_q == 2'(BYTES_PER_WORD - 1));
   assign word       = {sh_q, din};

endmodule

// File: rtl/kgp_boot_loader.sv
// Loads a length/data/checksum frame into instruction memory from address 0.
// The core is held in reset until the image checksum has been verified.
module kgp_boot_loader
   import kgp_boot_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   kgp_boot_if.slave         host,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              error
);

   localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

   boot_state_t state_q, state_d;

   logic              rdy;
   logic              acc;
   logic [7:0]        len_hi_q;
   logic [15:0]       len;
   logic [15:0]       rem_q;
   logic [7:0]        csum_q;
   logic              we_q;
   logic              asm_en;
   logic [WORD_W-1:0] word;
   logic              word_valid;

   assign rdy = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                (state_q == S_DATA)   || (state_q == S_CHK);
   assign host.in_ready = rdy;
   assign acc    = host.in_valid && rdy;
   assign len    = {len_hi_q, host.in_data};
   assign asm_en = acc && (state_q == S_DATA);

   kgp_word_assembler #(
      .WORD_W (WORD_W)
   ) u_asm (
      .clk        (clk),
      .rst        (rst),
      .en         (asm_en),
      .din        (host.in_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_LEN_HI;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_LEN_HI: begin
            if (acc) state_d = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (acc) begin
               if ({1'b0, len} > CAP) state_d = S_ERR;
               else if (len == 16'd0) state_d = S_CHK;
               else                   state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (word_valid && rem_q == 16'd1) state_d = S_CHK;
         end
         S_CHK: begin
            if (acc) begin
               if (host.in_data == csum_q) state_d = S_DONE;
               else                        state_d = S_ERR;
            end
         end
         S_DONE:  state_d = S_DONE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_LEN_HI;
      endcase
   end

   // Completed words are copied out so the next word can assemble meanwhile.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_hi_q   <= '0;
         rem_q      <= '0;
         csum_q     <= '0;
         we_q       <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         we_q <= word_valid;
         if (acc && state_q == S_LEN_HI) len_hi_q <= host.in_data;
         if (acc && state_q == S_LEN_LO) rem_q <= len;
         if (asm_en) csum_q <= csum_q ^ host.in_data;
         if (word_valid) begin
            rem_q      <= rem_q - 16'd1;
            imem_wdata <= word;
         end
         if (we_q) imem_addr <= imem_addr + 1'b1;
      end
   end

   assign imem_we = we_q && !rst;
   assign cpu_rst = rst || (state_q != S_DONE);
   assign done    = (state_q == S_DONE);
   assign error   = (state_q == S_ERR);

endmodule

// File: tb/tb_kgp_boot_loader.sv
// Directed bench for kgp_boot_loader: good, bad, empty, overflow,
// gapped and reset-interrupted frames.
module tb_kgp_boot_loader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   kgp_boot_if hif ();
   kgp_boot_if hif4 ();

   logic        imem_we, cpu_rst, done, error;
   logic [9:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        we4, cpu_rst4, done4, error4;
   logic [3:0]  addr4;
   logic [31:0] wdata4;

   kgp_boot_loader #(.ADDR_W(10), .WORD_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .host       (hif.slave),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .done       (done),
      .error      (error)
   );

   kgp_boot_loader #(.ADDR_W(4), .WORD_W(32)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .host       (hif4.slave),
      .imem_we    (we4),
      .imem_addr  (addr4),
      .imem_wdata (wdata4),
      .cpu_rst    (cpu_rst4),
      .done       (done4),
      .error      (error4)
   );

   int nc = 0;
   int nf = 0;

   logic [9:0]  wa[$];
   logic [31:0] wd[$];
   int          nw4 = 0;

   // XOR of the eight data bytes below is 0x00.
   logic [7:0] frm [11] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                            8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};

   always @(negedge clk) begin
      if (imem_we) begin
         wa.push_back(imem_addr);
         wd.push_back(imem_wdata);
      end
      if (we4) nw4++;
   end

   task automatic send(input bit u4, input logic [7:0] b, input int gap);
      logic r;
      repeat (gap) begin
         @(negedge clk);
         hif.in_valid  = 1'b0;
         hif4.in_valid = 1'b0;
      end
      @(negedge clk);
      if (u4) begin
         hif4.in_data = b; hif4.in_valid = 1'b1;
      end else begin
         hif.in_data = b; hif.in_valid = 1'b1;
      end
      #1;
      r = u4 ? hif4.in_ready : hif.in_ready;
      nc++;
      if (r !== 1'b1) begin
         nf++;
         $display("FAIL send_ready: in_ready=%b required 1 (byte %h)", r, b);
      end
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      hif.in_valid  = 1'b0;
      hif4.in_valid = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      hif.in_valid  = 1'b0;
      hif4.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wa.delete();
      wd.delete();
      nw4 = 0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      nc++;
      if ({hif.in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error}
          !== {1'b1, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
         nf++;
         $display("FAIL reset: rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b required 1 0 000 00000000 1 0 0",
                  hif.in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error);
      end
      nc++;
      if ({hif4.in_ready, we4, cpu_rst4, done4, error4} !== 5'b10100) begin
         nf++;
         $display("FAIL reset4: got %b required 10100",
                  {hif4.in_ready, we4, cpu_rst4, done4, error4});
      end
   endtask

   task automatic test_load();
      do_reset();
      for (int i = 0; i < 10; i++) send(1'b0, frm[i], 0);
      idle();
      nc++;
      if ({done, cpu_rst} !== 2'b01) begin
         nf++;
         $display("FAIL load_pre_csum: done,cpu_rst=%b required 01", {done, cpu_rst});
      end
      send(1'b0, frm[10], 0);
      idle();
      nc++;
      if ({done, cpu_rst, error, hif.in_ready} !== 4'b1000) begin
         nf++;
         $display("FAIL load_done: done,crst,err,rdy=%b required 1000",
                  {done, cpu_rst, error, hif.in_ready});
      end
      nc++;
      if (wa.size() != 2 || {wa[0], wd[0], wa[1], wd[1]} !==
          {10'd0, 32'h12345678, 10'd1, 32'h9ABCDEF0}) begin
         nf++;
         $display("FAIL load_writes: n=%0d a0=%h d0=%h a1=%h d1=%h required 2 000 12345678 001 9abcdef0",
                  wa.size(), wa[0], wd[0], wa[1], wd[1]);
      end
   endtask

   task automatic test_bad_csum();
      do_reset();
      for (int i = 0; i < 10; i++) send(1'b0, frm[i], 0);
      send(1'b0, 8'h09, 0);
      idle();
      nc++;
      if ({done, cpu_rst, error, hif.in_ready} !== 4'b0110) begin
         nf++;
         $display("FAIL bad_csum: done,crst,err,rdy=%b required 0110",
                  {done, cpu_rst, error, hif.in_ready});
      end
      nc++;
      if (wa.size() != 2 || {wd[0], wd[1]} !== {32'h12345678, 32'h9ABCDEF0}) begin
         nf++;
         $display("FAIL bad_csum_writes: n=%0d d0=%h d1=%h required 2 12345678 9abcdef0",
                  wa.size(), wd[0], wd[1]);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         hif.in_data  = 8'(8'hA0 + i);
         hif.in_valid = 1'b1;
      end
      idle();
      idle();
      nc++;
      if ({error, cpu_rst, hif.in_ready} !== 3'b110 || wa.size() != 2) begin
         nf++;
         $display("FAIL err_sticky: err,crst,rdy=%b n=%0d required 110 2",
                  {error, cpu_rst, hif.in_ready}, wa.size());
      end
   endtask

   task automatic test_zero_len();
      do_reset();
      send(1'b0, 8'h00, 0);
      send(1'b0, 8'h00, 0);
      idle();
      nc++;
      if ({done, hif.in_ready} !== 2'b01) begin
         nf++;
         $display("FAIL zero_len_pre: done,rdy=%b required 01", {done, hif.in_ready});
      end
      send(1'b0, 8'h00, 0);
      idle();
      nc++;
      if ({done, cpu_rst, error} !== 3'b100 || wa.size() != 0) begin
         nf++;
         $display("FAIL zero_len: done,crst,err=%b writes=%0d required 100 0",
                  {done, cpu_rst, error}, wa.size());
      end
   endtask

   task automatic test_overflow();
      do_reset();
      send(1'b1, 8'h00, 0);
      send(1'b1, 8'h11, 0);
      idle();
      nc++;
      if ({error4, cpu_rst4, hif4.in_ready, done4} !== 4'b1100 || nw4 != 0) begin
         nf++;
         $display("FAIL overflow: err,crst,rdy,done=%b writes=%0d required 1100 0",
                  {error4, cpu_rst4, hif4.in_ready, done4}, nw4);
      end
      do_reset();
      send(1'b1, 8'h00, 0);
      send(1'b1, 8'h10, 0);
      idle();
      nc++;
      if ({error4, hif4.in_ready} !== 2'b01) begin
         nf++;
         $display("FAIL len_at_cap: err,rdy=%b required 01", {error4, hif4.in_ready});
      end
   endtask

   task automatic test_gaps();
      do_reset();
      for (int i = 0; i < 11; i++) send(1'b0, frm[i], $urandom_range(0, 5));
      idle();
      nc++;
      if ({done, cpu_rst, error} !== 3'b100) begin
         nf++;
         $display("FAIL gaps_done: done,crst,err=%b required 100", {done, cpu_rst, error});
      end
      nc++;
      if (wa.size() != 2 || {wa[0], wd[0], wa[1], wd[1]} !==
          {10'd0, 32'h12345678, 10'd1, 32'h9ABCDEF0}) begin
         nf++;
         $display("FAIL gaps_writes: n=%0d a0=%h d0=%h a1=%h d1=%h required 2 000 12345678 001 9abcdef0",
                  wa.size(), wa[0], wd[0], wa[1], wd[1]);
      end
   endtask

   task automatic test_rst_midload();
      do_reset();
      for (int i = 0; i < 6; i++) send(1'b0, frm[i], 0);
      @(negedge clk);
      rst = 1'b1;
      hif.in_valid = 1'b0;
      #1;
      nc++;
      if ({imem_we, cpu_rst} !== 2'b01) begin
         nf++;
         $display("FAIL rst_cycle: we,crst=%b required 01", {imem_we, cpu_rst});
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      nc++;
      if ({hif.in_ready, imem_addr, done, error, wa.size() == 0} !==
          {1'b1, 10'd0, 1'b0, 1'b0, 1'b1}) begin
         nf++;
         $display("FAIL rst_after: rdy=%b a=%h done=%b err=%b writes=%0d required 1 000 0 0 0",
                  hif.in_ready, imem_addr, done, error, wa.size());
      end
      for (int i = 0; i < 11; i++) send(1'b0, frm[i], 0);
      idle();
      nc++;
      if (done !== 1'b1 || wa.size() != 2 || {wa[0], wd[0], wa[1], wd[1]} !==
          {10'd0, 32'h12345678, 10'd1, 32'h9ABCDEF0}) begin
         nf++;
         $display("FAIL rst_reload: done=%b n=%0d a0=%h d0=%h a1=%h d1=%h required 1 2 000 12345678 001 9abcdef0",
                  done, wa.size(), wa[0], wd[0], wa[1], wd[1]);
      end
   endtask

   initial begin
      hif.in_data   = 8'h00;
      hif.in_valid  = 1'b0;
      hif4.in_data  = 8'h00;
      hif4.in_valid = 1'b0;
      test_reset();
      test_load();
      test_bad_csum();
      test_zero_len();
      test_overflow();
      test_gaps();
      test_rst_midload();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
      $finish;
   end

endmodule
